// File: rtl/switch_ingress_port.sv
// Ingress port of the switch: frames the serial byte stream, buffers one packet,
// decodes its destination address and forwards it on a valid/ready byte stream.
module switch_ingress_port #(
   parameter int                     MAX_LEN   = 16,
   parameter int                     NUM_PORTS = 4,
   parameter logic [NUM_PORTS*8-1:0] PORT_ADDR = {8'h04, 8'h03, 8'h02, 8'h01}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           data_in,
   input  logic                 sw_enable_in,
   output logic                 read_out,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic [NUM_PORTS-1:0] out_port_sel,
   output logic                 pkt_drop
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = $clog2(MAX_LEN);
   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
   localparam logic [LW-1:0] MIN_LEN_L = LW'(3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_DECODE,
      S_FWD,
      S_DROP
   } state_t;

   state_t               state_q, state_d;
   logic                 en_q, en_d;
   logic [LW-1:0]        len_q, len_d;
   logic [LW-1:0]        rd_q, rd_d;
   logic [NUM_PORTS-1:0] port_sel_q, port_sel_d;
   logic                 out_valid_q, out_valid_d;
   logic [7:0]           out_data_q, out_data_d;
   logic                 pkt_drop_q, pkt_drop_d;

   logic [7:0]           pkt_buf_q [MAX_LEN];
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;

   logic [NUM_PORTS-1:0] match_sel;
   logic                 match_any;
   logic [LW-1:0]        rd_next;
   logic                 last_byte;

   assign rd_next   = rd_q + LW'(1);
   assign last_byte = (rd_q == (len_q - LW'(1)));

   // Address decode of the DA byte; scanning downwards lets the lowest matching index win.
   always_comb begin
      match_sel = '0;
      match_any = 1'b0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (pkt_buf_q[0] == PORT_ADDR[i*8 +: 8]) begin
            match_sel    = '0;
            match_sel[i] = 1'b1;
            match_any    = 1'b1;
         end
      end
   end

   // Next-state logic: framing, decode, forwarding handshake and drop handling.
   always_comb begin
      state_d     = state_q;
      en_d        = sw_enable_in;
      len_d       = len_q;
      rd_d        = rd_q;
      port_sel_d  = port_sel_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      pkt_drop_d  = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = len_q[AW-1:0];
      case (state_q)
         S_IDLE: begin
            if (sw_enable_in && !en_q) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               len_d   = LW'(1);
               state_d = S_RECV;
            end
         end
         S_RECV: begin
            if (sw_enable_in) begin
               if (len_q == MAX_LEN_L) begin
                  state_d = S_DROP;
               end else begin
                  wr_en = 1'b1;
                  len_d = len_q + LW'(1);
               end
            end else if (len_q < MIN_LEN_L) begin
               pkt_drop_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (match_any) begin
               port_sel_d  = match_sel;
               rd_d        = '0;
               out_valid_d = 1'b0;
               state_d     = S_FWD;
            end else begin
               pkt_drop_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         S_FWD: begin
            // The output byte lives in a register, so the first FWD cycle only loads it.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = pkt_buf_q[rd_q[AW-1:0]];
            end else if (out_ready) begin
               if (last_byte) begin
                  out_valid_d = 1'b0;
                  out_data_d  = 8'h00;
                  state_d     = S_IDLE;
               end else begin
                  rd_d       = rd_next;
                  out_data_d = pkt_buf_q[rd_next[AW-1:0]];
               end
            end
         end
         S_DROP: begin
            if (!sw_enable_in) begin
               pkt_drop_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers; enable history resets high so a live frame is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         en_q        <= 1'b1;
         len_q       <= '0;
         rd_q        <= '0;
         port_sel_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         pkt_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         len_q       <= len_d;
         rd_q        <= rd_d;
         port_sel_q  <= port_sel_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         pkt_drop_q  <= pkt_drop_d;
      end
   end

   // Packet buffer storage; contents are don't-care until written, so it has no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         pkt_buf_q[wr_addr] <= data_in;
      end
   end

   assign read_out     = (state_q == S_DECODE) || (state_q == S_FWD) || (state_q == S_DROP);
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_sop      = out_valid_q && (rd_q == '0);
   assign out_eop      = out_valid_q && last_byte;
   assign out_port_sel = out_valid_q ? port_sel_q : '0;
   assign pkt_drop     = pkt_drop_q;

endmodule

// File: tb/tb_switch_ingress_port.sv
// Directed bench for switch_ingress_port: cycle vector table plus hand-written
// sequences for output back-pressure and asynchronous reset mid-forward.
module tb_switch_ingress_port;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       sw_enable_in;
   logic       read_out;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_sop;
   logic       out_eop;
   logic [3:0] out_port_sel;
   logic       pkt_drop;

   int testsRun  = 0;
   int testsFail = 0;

   typedef struct {
      logic       en;
      logic [7:0] din;
      logic       rdy;
      logic       expRead;
      logic       expValid;
      logic [7:0] expData;
      logic       expSop;
      logic       expEop;
      logic [3:0] expSel;
      logic       expDrop;
   } vec_t;

   vec_t vecs[$];

   switch_ingress_port dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .sw_enable_in (sw_enable_in),
      .read_out     (read_out),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sop      (out_sop),
      .out_eop      (out_eop),
      .out_port_sel (out_port_sel),
      .pkt_drop     (pkt_drop)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic en, input logic [7:0] din, input logic rdy);
      sw_enable_in = en;
      data_in      = din;
      out_ready    = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] packOutputs();
      return {15'd0, read_out, out_valid, out_data, out_sop, out_eop, out_port_sel, pkt_drop};
   endfunction

   function automatic logic [31:0] packExpected(input vec_t v);
      return {15'd0, v.expRead, v.expValid, v.expData, v.expSop, v.expEop, v.expSel, v.expDrop};
   endfunction

   task automatic addVec(input logic en, input logic [7:0] din, input logic rdy,
                         input logic rd, input logic vld, input logic [7:0] d,
                         input logic s, input logic e, input logic [3:0] sel, input logic drp);
      vec_t v;
      v.en = en; v.din = din; v.rdy = rdy;
      v.expRead = rd; v.expValid = vld; v.expData = d;
      v.expSop = s; v.expEop = e; v.expSel = sel; v.expDrop = drp;
      vecs.push_back(v);
   endtask

   task automatic addIdle();
      addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic addRecv(input logic [7:0] din);
      addVec(1'b1, din, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic buildTable();
      // Reset-release cycle so the enable history is seen low.
      addIdle();
      // Frame 02,AA,11,22 to port 1 with out_ready high.
      addRecv(8'h02); addRecv(8'hAA); addRecv(8'h11); addRecv(8'h22);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 4'b0010, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 4'b0010, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 4'b0010, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 4'b0010, 1'b0);
      addIdle();
      // Unknown DA 07, started in the IDLE cycle right after eop acceptance.
      addRecv(8'h07); addRecv(8'hAA); addRecv(8'h55);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b1);
      addIdle();
      // Runt frame 01,AA.
      addRecv(8'h01); addRecv(8'hAA);
      addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b1);
      addIdle();
      // 20-byte frame: 16 bytes fill the buffer, the 17th overflows into DROP.
      for (int k = 0; k < 16; k++) addRecv(8'h01);
      for (int k = 16; k < 20; k++)
         addVec(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b1);
      addIdle();
      // Frame 01,BB,CC to port 0, with a second frame asserted during FWD.
      addRecv(8'h01); addRecv(8'hBB); addRecv(8'hCC);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 4'b0001, 1'b0);
      addVec(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 4'b0001, 1'b0);
      addVec(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b1, 4'b0001, 1'b0);
      addVec(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addIdle();
      // Next frame 03,DD,EE after IDLE forwards normally to port 2.
      addRecv(8'h03); addRecv(8'hDD); addRecv(8'hEE);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 4'b0100, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b0, 4'b0100, 1'b0);
      addVec(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 4'b0100, 1'b0);
      addIdle();
   endtask

   // Frame 02,AA,11,22 with out_ready toggling 1,0,0,1 while bytes are offered.
   task automatic runReadyToggle();
      logic [7:0] expBytes [4];
      logic       pattern [4];
      logic       hold;
      logic [7:0] holdData;
      logic       holdSop;
      logic       holdEop;
      logic       done;
      int         got;
      int         eops;
      int         k;
      expBytes[0] = 8'h02; expBytes[1] = 8'hAA; expBytes[2] = 8'h11; expBytes[3] = 8'h22;
      pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
      hold = 1'b0; holdData = 8'h00; holdSop = 1'b0; holdEop = 1'b0;
      done = 1'b0; got = 0; eops = 0; k = 0;
      for (int b = 0; b < 4; b++) begin
         applyStimulus(1'b1, expBytes[b], 1'b0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (hold) begin
            checkOutput($sformatf("toggle hold c%0d", c),
                        {22'd0, out_valid, out_data, out_sop},
                        {22'd0, 1'b1, holdData, holdSop});
            checkOutput($sformatf("toggle hold eop c%0d", c), {31'd0, out_eop}, {31'd0, holdEop});
         end
         if (out_valid) begin
            out_ready = pattern[k % 4];
            k++;
            if (out_ready) begin
               if (got < 4) begin
                  checkOutput($sformatf("toggle byte%0d", got),
                              {22'd0, out_data, out_sop, out_eop},
                              {22'd0, expBytes[got], (got == 0), (got == 3)});
               end
               if (out_eop) begin
                  eops++;
                  done = 1'b1;
               end
               got++;
               hold = 1'b0;
            end else begin
               hold     = 1'b1;
               holdData = out_data;
               holdSop  = out_sop;
               holdEop  = out_eop;
            end
         end else begin
            out_ready = 1'b0;
         end
      end
      checkOutput("toggle completed in budget", {31'd0, done}, 32'd1);
      checkOutput("toggle byte count", got, 32'd4);
      checkOutput("toggle eop count", eops, 32'd1);
      @(negedge clk);
      checkOutput("toggle idle after eop", packOutputs(), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
   endtask

   // Reset pulsed mid-forward, then enable held high across reset release.
   task automatic runResetMidForward();
      logic seen;
      seen = 1'b0;
      applyStimulus(1'b1, 8'h01, 1'b1); @(negedge clk);
      applyStimulus(1'b1, 8'h11, 1'b1); @(negedge clk);
      applyStimulus(1'b1, 8'h22, 1'b1); @(negedge clk);
      applyStimulus(1'b1, 8'h33, 1'b1); @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = out_valid;
      end
      checkOutput("reset test reached FWD", {31'd0, seen}, 32'd1);
      #2;
      rst_n = 1'b0;
      sw_enable_in = 1'b1;
      data_in = 8'h02;
      #1;
      checkOutput("async reset clears outputs", packOutputs(), 32'd0);
      #9;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput($sformatf("enable held over release c%0d", c), packOutputs(), 32'd0);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("quiet after release c%0d", c), packOutputs(), 32'd0);
      end
      // A fresh frame after the ignored one is accepted normally.
      applyStimulus(1'b1, 8'h04, 1'b1); @(negedge clk);
      applyStimulus(1'b1, 8'h55, 1'b1); @(negedge clk);
      applyStimulus(1'b1, 8'h66, 1'b1); @(negedge clk);
      applyStimulus(1'b0, 8'h00, 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = out_valid;
      end
      checkOutput("post-reset frame first byte",
                  {19'd0, seen, out_data, out_port_sel},
                  {19'd0, 1'b1, 8'h04, 4'b1000});
   endtask

   // Main sequence: reset, vector table, then the hand-written corner cases.
   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("reset state", packOutputs(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      buildTable();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].en, vecs[i].din, vecs[i].rdy);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), packOutputs(), packExpected(vecs[i]));
      end
      runReadyToggle();
      @(negedge clk);
      runResetMidForward();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
